// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, init ROM, command codes and default timings for the LCD sequencer.
package lcd_pkg;
   typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE} state_t;
   localparam int unsigned INIT_LEN = 8;
   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam int unsigned T_SETUP_DEF  = 2;
   localparam int unsigned T_EPULSE_DEF = 13;
   localparam int unsigned T_EXEC_DEF   = 2100;
   localparam int unsigned T_HOME_DEF   = 82000;
   localparam int unsigned T_PWRUP_DEF  = 750000;
   localparam int unsigned T_INIT1_DEF  = 205000;
   localparam int unsigned T_INIT2_DEF  = 5000;
   // A zero-length phase would never complete, so it is stretched to one cycle.
   function automatic logic [31:0] nz(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction
endpackage

// File: rtl/lcd_wait_timer.sv
// lcd_wait_timer: countdown shared by every phase; counts 0..N-1 after a load and pulses done on the last count.
module lcd_wait_timer
   import lcd_pkg::*;
#(
   parameter logic [31:0] RST_VAL = 32'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic        done
);
   logic [31:0] cnt_q, lim_q;
   logic        run_q;
   assign done = run_q && (cnt_q == lim_q - 32'd1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         lim_q <= nz(RST_VAL);
         run_q <= 1'b1;
      end else if (load) begin
         cnt_q <= '0;
         lim_q <= nz(load_val);
         run_q <= 1'b1;
      end else if (done) begin
         run_q <= 1'b0;
      end else if (run_q) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end
endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 8-bit bus driver with power-on init and a valid/ready write port.
// Defining LCD_SIM_FAST_EN shortens all wait counts for simulation; setup and E-pulse widths are unchanged.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP  = T_SETUP_DEF,
   parameter int unsigned T_EPULSE = T_EPULSE_DEF,
   parameter int unsigned T_EXEC   = T_EXEC_DEF,
   parameter int unsigned T_HOME   = T_HOME_DEF,
   parameter int unsigned T_PWRUP  = T_PWRUP_DEF,
   parameter int unsigned T_INIT1  = T_INIT1_DEF,
   parameter int unsigned T_INIT2  = T_INIT2_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);
`ifdef LCD_SIM_FAST_EN
   localparam logic [31:0] W_PWRUP = 32'd20;
   localparam logic [31:0] W_INIT1 = 32'd10;
   localparam logic [31:0] W_INIT2 = 32'd5;
   localparam logic [31:0] W_EXEC  = 32'd4;
   localparam logic [31:0] W_HOME  = 32'd8;
`else
   localparam logic [31:0] W_PWRUP = T_PWRUP;
   localparam logic [31:0] W_INIT1 = T_INIT1;
   localparam logic [31:0] W_INIT2 = T_INIT2;
   localparam logic [31:0] W_EXEC  = T_EXEC;
   localparam logic [31:0] W_HOME  = T_HOME;
`endif
   localparam logic [31:0] W_SETUP  = T_SETUP;
   localparam logic [31:0] W_EPULSE = T_EPULSE;
   state_t      state_q, state_d;
   logic [7:0]  data_q, data_d;
   logic        rs_q, rs_d, init_done_q, init_done_d, ready_q;
   logic [2:0]  idx_q, idx_d;
   logic        load, done, accept, is_home;
   logic [31:0] load_val, exec_wait;
   assign accept    = ready_q & req_valid;
   assign is_home   = !rs_q && (data_q == CMD_CLEAR || data_q == CMD_HOME || data_q == 8'h03);
   assign exec_wait = (!init_done_q && idx_q == 3'd0) ? W_INIT1 :
                      (!init_done_q && idx_q == 3'd1) ? W_INIT2 :
                      is_home ? W_HOME : W_EXEC;
   lcd_wait_timer #(.RST_VAL(W_PWRUP)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      rs_d        = rs_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      load        = 1'b0;
      load_val    = W_SETUP;
      case (state_q)
         S_PWRUP: if (done) begin
            state_d = S_SETUP;
            data_d  = INIT_ROM[0];
            rs_d    = 1'b0;
            idx_d   = 3'd0;
            load    = 1'b1;
         end
         S_SETUP: if (done) begin
            state_d  = S_PULSE;
            load     = 1'b1;
            load_val = W_EPULSE;
         end
         S_PULSE: if (done) begin
            state_d = S_HOLD;
            load    = 1'b1;
         end
         S_HOLD: if (done) begin
            state_d  = S_EXEC;
            load     = 1'b1;
            load_val = exec_wait;
         end
         S_EXEC: if (done) begin
            if (!init_done_q && idx_q != 3'(INIT_LEN - 1)) begin
               idx_d   = idx_q + 3'd1;
               data_d  = INIT_ROM[idx_q + 3'd1];
               state_d = S_SETUP;
               load    = 1'b1;
            end else begin
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_IDLE: if (accept) begin
            state_d = S_SETUP;
            data_d  = req_data;
            rs_d    = req_rs;
            load    = 1'b1;
         end
         default: state_d = S_PWRUP;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_PWRUP;
         data_q      <= 8'h00;
         rs_q        <= 1'b0;
         idx_q       <= 3'd0;
         init_done_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         ready_q     <= (state_d == S_IDLE);
      end
   end
   assign req_ready = ready_q;
   assign busy      = ~ready_q;
   assign init_done = init_done_q;
   assign lcd_e     = (state_q == S_PULSE);
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = data_q;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed checks of init sequence, user writes, wait selection, request capture and reset abort.
module tb_lcd_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;
   int n_vec = 0;
   int n_err = 0;
   int rw_bad = 0;
   localparam int BOUND = 500;
   localparam logic [7:0] INIT_D [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
   localparam int INIT_GAP [8] = '{22, 14, 9, 8, 8, 8, 12, 8};

   lcd_cmd_sequencer #(
      .T_SETUP(2), .T_EPULSE(13), .T_EXEC(4), .T_HOME(8),
      .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .req_ready (req_ready),
      .init_done (init_done),
      .busy      (busy),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (lcd_rw !== 1'b0) rw_bad++;

   // Counts low negedge samples (starting with the current one) up to the next E pulse, then measures it.
   task automatic get_pulse(output int gap, output int width, output logic [7:0] d, output logic r, output logic stable);
      gap = 0;
      while (!lcd_e && gap < BOUND) begin
         gap++;
         @(negedge clk);
      end
      d = lcd_data;
      r = lcd_rs;
      width = 0;
      stable = 1'b1;
      while (lcd_e && width < BOUND) begin
         width++;
         if (lcd_data !== d || lcd_rs !== r) stable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({lcd_e, lcd_rs, lcd_rw, lcd_data} !== 11'h0) begin
         n_err++;
         $display("FAIL reset_bus: got e=%b rs=%b rw=%b data=%h, want all 0", lcd_e, lcd_rs, lcd_rw, lcd_data);
      end
      n_vec++;
      if ({req_ready, init_done, busy} !== 3'b001) begin
         n_err++;
         $display("FAIL reset_status: got ready/init_done/busy=%b, want 001", {req_ready, init_done, busy});
      end
   endtask

   task automatic test_init;
      int gap, width, n;
      logic [7:0] d;
      logic r, st;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         get_pulse(gap, width, d, r, st);
         n_vec++;
         if (gap !== INIT_GAP[i]) begin
            n_err++;
            $display("FAIL init_gap[%0d]: got %0d cycles, want %0d", i, gap, INIT_GAP[i]);
         end
         n_vec++;
         if ({width, d, r, st} !== {32'd13, INIT_D[i], 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL init_pulse[%0d]: got width=%0d data=%h rs=%b stable=%b, want 13 %h 0 1", i, width, d, r, st, INIT_D[i]);
         end
      end
      n = 0;
      while (!req_ready && n < BOUND) begin
         n++;
         @(negedge clk);
      end
      n_vec++;
      if (n !== 6 || init_done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL init_end: got ready after %0d init_done=%b busy=%b, want 6 1 0", n, init_done, busy);
      end
   endtask

   task automatic test_write(input logic rs, input logic [7:0] data, input int w, input bit hold);
      int gap, width, n;
      logic [7:0] d;
      logic r, st;
      req_valid = 1'b1;
      req_rs = rs;
      req_data = data;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL accept_%h: got ready=%b busy=%b, want 0 1", data, req_ready, busy);
      end
      if (hold) begin
         req_rs = ~rs;
         req_data = ~data;
      end else req_valid = 1'b0;
      get_pulse(gap, width, d, r, st);
      n_vec++;
      if ({gap, width, d, r, st} !== {32'd2, 32'd13, data, rs, 1'b1}) begin
         n_err++;
         $display("FAIL write_%h: got gap=%0d width=%0d data=%h rs=%b stable=%b, want 2 13 %h %b 1", data, gap, width, d, r, st, data, rs);
      end
      n = 0;
      while (!req_ready && n < BOUND) begin
         n++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_vec++;
      if (n !== 2 + w) begin
         n_err++;
         $display("FAIL exec_%h: got ready after %0d, want %0d (total %0d vs %0d)", data, n, 2 + w, 1 + gap + width + n, 18 + w);
      end
   endtask

   task automatic test_commands;
      test_write(1'b1, 8'h41, 4, 1'b0);
      test_write(1'b0, 8'h01, 8, 1'b0);
      test_write(1'b0, 8'h80, 4, 1'b0);
      test_write(1'b0, 8'h02, 8, 1'b0);
      test_write(1'b0, 8'h03, 8, 1'b0);
      test_write(1'b1, 8'h01, 4, 1'b0);
      test_write(1'b0, 8'h04, 4, 1'b0);
   endtask

   task automatic test_back_to_back;
      int e_cnt;
      test_write(1'b0, 8'h5A, 4, 1'b1);
      e_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (lcd_e || !req_ready) e_cnt++;
      end
      n_vec++;
      if (e_cnt !== 0) begin
         n_err++;
         $display("FAIL no_extra_pulse: got %0d busy/E samples after held request, want 0", e_cnt);
      end
   endtask

   task automatic test_reset_mid_write;
      int n;
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'h55;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!lcd_e && n < BOUND) begin
         n++;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (lcd_e !== 1'b1) begin
         n_err++;
         $display("FAIL mid_write_e: got e=%b before reset, want 1", lcd_e);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({lcd_e, init_done, req_ready, busy, lcd_data} !== {4'b0001, 8'h00}) begin
         n_err++;
         $display("FAIL abort: got e=%b init_done=%b ready=%b busy=%b data=%h, want 0 0 0 1 00", lcd_e, init_done, req_ready, busy, lcd_data);
      end
      @(negedge clk);
      test_init();
      test_write(1'b1, 8'h42, 4, 1'b0);
   endtask

   initial begin
      test_reset();
      test_init();
      test_commands();
      test_back_to_back();
      test_reset_mid_write();
      n_vec++;
      if (rw_bad !== 0) begin
         n_err++;
         $display("FAIL lcd_rw: got %0d samples with rw!=0, want 0", rw_bad);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Drives an HD44780-class character LCD over its 8-bit parallel bus: RS, RW, E and DB[7:0].
- After reset it runs the fixed power-on init sequence by itself. It then accepts command and data bytes from the user logic through a valid/ready handshake.
- All bus setup, E-pulse and execution delays are counted in clk cycles (50 MHz, 20 ns per cycle). It sits between the display-content logic and the LCD pins.

Parameters:
- T_SETUP, 2, cycles RS/DB are stable before E rises, and held after E falls (40 ns)
- T_EPULSE, 13, cycles E is held high (250 ns min)
- T_EXEC, 2100, cycles of execution wait for ordinary commands and data writes (42 us)
- T_HOME, 82000, cycles of execution wait after Clear (0x01) or Home (0x02/0x03) (1640 us)
- T_PWRUP, 750000, cycles of wait after reset release before the first init write (15 ms)
- T_INIT1, 205000, cycles of wait after init step 0 (4.1 ms)
- T_INIT2, 5000, cycles of wait after init step 1 (100 us)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  user write request
- req_rs  in  1  0 = command, 1 = data
- req_data  in  8  byte to write
- req_ready  out  1  block can accept a request this cycle
- init_done  out  1  init sequence complete; stays high until the next reset
- busy  out  1  a write or wait is in progress (equals ~req_ready)
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied 0 (write-only)
- lcd_data  out  8  LCD DB[7:0]

Behaviour:
- Reset (async, rst=1) forces:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00
  - req_ready=0, init_done=0, busy=1
  - state=S_PWRUP, wait counter=0, init index=0
- rst asserted mid-write drops E immediately and aborts the write. After release the full init sequence restarts.
- States: S_PWRUP, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE.
- S_PWRUP: count T_PWRUP cycles, then load init ROM[0] and go to S_SETUP.
- Init ROM, all entries rs=0, steps 0..7: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C.
- Every write, init or user, takes the same path:
  - S_SETUP: E=0, RS/DB driven, T_SETUP cycles.
  - S_PULSE: E=1, T_EPULSE cycles.
  - S_HOLD: E=0, RS/DB unchanged, T_SETUP cycles.
  - S_EXEC: E=0, wait a count chosen per the wait-selection rule below.
- Wait selection in S_EXEC:
  - init step 0: T_INIT1
  - init step 1: T_INIT2
  - rs=0 and byte in {0x01, 0x02, 0x03}: T_HOME
  - otherwise: T_EXEC
- Leaving S_EXEC:
  - If init index < 7: increment the index and go to S_SETUP.
  - After step 7: set init_done=1, go to S_IDLE.
  - After a user write: go to S_IDLE.
- S_IDLE: req_ready=1.
  - A request is accepted when req_valid & req_ready; req_rs and req_data are captured that cycle.
  - Next cycle: req_ready=0 and state=S_SETUP.
- req_ready is registered and is never high outside S_IDLE. req_valid while not ready is ignored; no buffering.
- Each phase counter counts 0..N-1 and lasts exactly N cycles. A parameter value of 0 is treated as 1.
- Write latency: acceptance to E rising = 1 + T_SETUP cycles. Acceptance to req_ready high again = 1 + 2*T_SETUP + T_EPULSE + wait.
- Wait counter is 32 bits; it never wraps (all loads are below 2^32).
- lcd_data and lcd_rs change only in S_IDLE→S_SETUP transitions and init index steps, never while E=1.

Optional Feature:
- Macro: LCD_SIM_FAST_EN.
- Defined: the wait counts are overridden as follows; all other behaviour is identical.
  - T_PWRUP=20, T_INIT1=10, T_INIT2=5, T_EXEC=4, T_HOME=8
  - T_SETUP and T_EPULSE unchanged
- Not defined: parameter values apply unchanged.

Decomposition:
- Package lcd_pkg holds:
  - state encoding (3-bit)
  - init ROM contents and length (8)
  - command constants CLEAR=0x01 and HOME=0x02
  - default timing cycle counts
- One sub-module, lcd_wait_timer: load/count/done countdown shared by all phases.
  - Ports: clk, rst, load, load_val[31:0], done.
  - done pulses for 1 cycle on the final count.

Test Plan:
- Release rst, LCD_SIM_FAST_EN defined → first lcd_e rise at cycle 20+2; exactly 8 E pulses; lcd_data per pulse = 30,30,30,38,08,01,06,0C.
- After init_done, send req_rs=1, req_data=0x41 → req_ready low next cycle; E high 13 cycles with lcd_rs=1, lcd_data=0x41; req_ready back after 1+2+13+2+4 = 22 cycles.
- Send req_rs=0, req_data=0x01 → execution wait 8 cycles; req_rs=0, 0x80 → wait 4 cycles.
- Hold req_valid high continuously during a write with changing req_data → only the value present in the acceptance cycle appears on lcd_data; no extra E pulses.
- Assert rst for 1 cycle while lcd_e=1 during a user write → lcd_e=0 and init_done=0 immediately; after release the 8-step init sequence repeats.
- Default build (no macro), check timing of init step 0 → 205000 cycles from E fall + T_SETUP to the step-1 S_SETUP entry; lcd_rw is 0 throughout.
